pe_triple_dispatcher: RTL



---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_entry_fifo.sv | 52 +++++
 rtl/pe_triple_dispatcher.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types for the PE dispatcher: entry layout, dispatcher states, slot count.
package pe_pkg;

    localparam int unsigned PE_SLOTS     = 3;
    localparam int unsigned PE_ADDR_BITS = 7;
    localparam int unsigned PE_DATA_BITS = 16;

    typedef logic [2:0][PE_ADDR_BITS-1:0] pe_addr_t;

    typedef struct packed {
        pe_addr_t                        addr;
        logic signed [PE_DATA_BITS-1:0]  w;
        logic signed [PE_DATA_BITS-1:0]  ia;
        logic                            last;
    } pe_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } pe_disp_state_t;

endpackage

// File: rtl/pe_entry_fifo.sv
// Synchronous FIFO of sparse entries with a three-entry head peek and a 0..3 pop count.
module pe_entry_fifo
    import pe_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  pe_entry_t                  i_entry,
    input  logic [1:0]                 i_pop_n,
    output pe_entry_t                  o_head [PE_SLOTS],
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);

    pe_entry_t             mem [DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS:0]     count;

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem[wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr <= rd_ptr + PTR_BITS'(i_pop_n);
            count  <= count + (PTR_BITS+1)'(i_push) - (PTR_BITS+1)'(i_pop_n);
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < PE_SLOTS; k++) begin
            o_head[k] = mem[rd_ptr + PTR_BITS'(k)];
        end
    end

    assign o_count = count;

endmodule

// File: rtl/pe_triple_dispatcher.sv
// Packs FIFO'd sparse entries into padded groups of three for the PE reducer.
// Optional PE_DISPATCH_STALL_CNT_EN adds the o_stall_cnt stall-cycle counter.
module pe_triple_dispatcher
    import pe_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_BITS  = 7,
    parameter int unsigned DATA_BITS  = 16,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [3*ADDR_BITS-1:0]      i_addr,
    input  logic [DATA_BITS-1:0]        i_w,
    input  logic [DATA_BITS-1:0]        i_ia,
    input  logic                        i_last,
    output logic                        o_start,
    output logic [9*ADDR_BITS-1:0]      o_addr,
    output logic [3*DATA_BITS-1:0]      o_w,
    output logic [3*DATA_BITS-1:0]      o_ia,
    input  logic                        i_finish,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [CNT_BITS-1:0]         o_grp_cnt
`ifdef PE_DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]                 o_stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned AW = 3 * ADDR_BITS;

    pe_entry_t         in_entry;
    pe_entry_t         head [PE_SLOTS];
    logic [CW-1:0]     fifo_count;
    logic              push;
    logic [1:0]        pop_n;

    logic              grp_ready;
    logic              grp_last;
    logic [1:0]        grp_n;
    logic [1:0]        pad_src;

    pe_disp_state_t    state;
    pe_disp_state_t    state_next;
    logic              grp_last_q;

    logic [AW-1:0]        slot_addr [PE_SLOTS];
    logic [DATA_BITS-1:0] slot_w    [PE_SLOTS];
    logic [DATA_BITS-1:0] slot_ia   [PE_SLOTS];
    logic [AW-1:0]        addr_q    [PE_SLOTS];
    logic [DATA_BITS-1:0] w_q       [PE_SLOTS];
    logic [DATA_BITS-1:0] ia_q      [PE_SLOTS];
    logic [CNT_BITS-1:0]  grp_cnt;

    assign o_ready = (fifo_count < CW'(FIFO_DEPTH));
    assign push    = i_valid & o_ready;

    always_comb begin
        in_entry.addr = i_addr;
        in_entry.w    = i_w;
        in_entry.ia   = i_ia;
        in_entry.last = i_last;
    end

    pe_entry_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_entry (in_entry),
        .i_pop_n (pop_n),
        .o_head  (head),
        .o_count (fifo_count)
    );

    // Head group stops at the first last-flagged entry so tiles never share a group.
    always_comb begin
        grp_ready = 1'b0;
        grp_last  = 1'b0;
        grp_n     = 2'd0;
        if (fifo_count >= CW'(1) && head[0].last) begin
            grp_ready = 1'b1;
            grp_last  = 1'b1;
            grp_n     = 2'd1;
        end else if (fifo_count >= CW'(2) && head[1].last) begin
            grp_ready = 1'b1;
            grp_last  = 1'b1;
            grp_n     = 2'd2;
        end else if (fifo_count >= CW'(3)) begin
            grp_ready = 1'b1;
            grp_last  = head[2].last;
            grp_n     = 2'd3;
        end
    end

    // Pad slots reuse the last real address with zero data so the reducer merges them.
    assign pad_src = (grp_n == 2'd0) ? 2'd0 : grp_n - 2'd1;

    always_comb begin
        for (int unsigned s = 0; s < PE_SLOTS; s++) begin
            if (s < 32'(grp_n)) begin
                slot_addr[s] = head[s].addr;
                slot_w[s]    = head[s].w;
                slot_ia[s]   = head[s].ia;
            end else begin
                slot_addr[s] = head[pad_src].addr;
                slot_w[s]    = '0;
                slot_ia[s]   = '0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop_n      = 2'd0;
        o_start    = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (grp_ready) begin
                    pop_n      = grp_n;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_start    = 1'b1;
                o_busy     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_finish) begin
                    state_next = grp_last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grp_last_q <= 1'b0;
            grp_cnt    <= '0;
            for (int unsigned s = 0; s < PE_SLOTS; s++) begin
                addr_q[s] <= '0;
                w_q[s]    <= '0;
                ia_q[s]   <= '0;
            end
        end else begin
            if (state == S_IDLE && grp_ready) begin
                grp_last_q <= grp_last;
                for (int unsigned s = 0; s < PE_SLOTS; s++) begin
                    addr_q[s] <= slot_addr[s];
                    w_q[s]    <= slot_w[s];
                    ia_q[s]   <= slot_ia[s];
                end
            end
            if (state == S_ISSUE) begin
                grp_cnt <= grp_cnt + 1'b1;
            end
        end
    end

    assign o_addr    = {addr_q[2], addr_q[1], addr_q[0]};
    assign o_w       = {w_q[2], w_q[1], w_q[0]};
    assign o_ia      = {ia_q[2], ia_q[1], ia_q[0]};
    assign o_grp_cnt = grp_cnt;

`ifdef PE_DISPATCH_STALL_CNT_EN
    logic        stall_cyc;
    logic [31:0] stall_cnt;

    assign stall_cyc = (state == S_WAIT) ||
                       (state == S_IDLE && fifo_count != '0 && !grp_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (stall_cyc && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt;
`endif

endmodule
